// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - Byte-wide data memory slave with programmable wait states
module data_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    output logic [7:0] resp_rdata,
    output logic       resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_W   = 9'(DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

    state_t     state;
    logic [3:0] cnt;
    logic       lat_write;
    logic [7:0] lat_addr;
    logic [7:0] lat_wdata;

    logic [7:0] mem [DEPTH];

    logic          handshake;
    logic          commit;
    logic          c_write;
    logic [7:0]    c_addr;
    logic [7:0]    c_wdata;
    logic          c_in_range;
    logic [AW-1:0] c_idx;
    logic [7:0]    rdata_next;
    logic          err_next;

    assign handshake = req_valid & req_ready;

    // Select the transaction being committed: with no wait states the commit
    // edge is the acceptance edge, so the live request is used directly.
    always_comb begin
        c_write    = lat_write;
        c_addr     = lat_addr;
        c_wdata    = lat_wdata;
        if (state == IDLE) begin
            c_write = req_write;
            c_addr  = req_addr;
            c_wdata = req_wdata;
        end
        c_in_range = ({1'b0, c_addr} < DEPTH_W);
        c_idx      = c_addr[AW-1:0];
        commit     = rst_n && (((state == IDLE) && handshake && NO_WAIT) ||
                               ((state == WAIT) && (cnt == 4'd0)));
        err_next   = !c_in_range;
        rdata_next = 8'h00;
        if (!c_write && c_in_range) begin
            rdata_next = mem[c_idx];
        end
    end

    // Storage write port; not reset, and gated so an abandoned store never lands.
    always_ff @(posedge clk) begin
        if (commit && c_write && c_in_range) begin
            mem[c_idx] <= c_wdata;
        end
    end

    // Access sequencer: accept, count wait states, emit a one-cycle response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 8'h00;
            resp_err   <= 1'b0;
            lat_write  <= 1'b0;
            lat_addr   <= 8'h00;
            lat_wdata  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    if (handshake) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        if (NO_WAIT) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= rdata_next;
                            resp_err   <= err_next;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    req_ready <= 1'b0;
                    if (cnt == 4'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= rdata_next;
                        resp_err   <= err_next;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - Directed and randomised checks of data_mem_responder
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: defaults, instance 1: no wait states, instance 2: DEPTH 64.
    logic [2:0] rst_n;
    logic [2:0] req_valid;
    logic [2:0] req_ready;
    logic [2:0] req_write;
    logic [2:0] resp_valid;
    logic [2:0] resp_err;
    logic [7:0] req_addr   [3];
    logic [7:0] req_wdata  [3];
    logic [7:0] resp_rdata [3];

    int wait_of [3] = '{2, 0, 2};

    int n_assert = 0;
    int n_fail   = 0;

    int outstanding [3] = '{0, 0, 0};
    int stray       [3] = '{0, 0, 0};

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u_d64 (
        .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2])
    );

    // Every response must be owed to an earlier handshake; reset forgives pending ones.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n[k]) begin
                outstanding[k] <= 0;
            end else if (req_valid[k] && req_ready[k]) begin
                outstanding[k] <= outstanding[k] + 1;
            end else if (resp_valid[k]) begin
                if (outstanding[k] == 0) stray[k] <= stray[k] + 1;
                else outstanding[k] <= outstanding[k] - 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int k, input string tag);
        int guard = 0;
        while (!req_ready[k] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_ready_tmo"}, 32'(guard < 50), 32'd1);
    endtask

    task automatic wait_resp(input int k, input string tag, output int lat);
        lat = 1;
        while (!resp_valid[k] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(wait_of[k] + 1));
    endtask

    // Called just after a negedge; returns at the negedge of the response cycle.
    task automatic do_req(input int k, input logic w, input logic [7:0] a, input logic [7:0] d,
                          input string tag, output logic [7:0] rd, output logic er);
        int lat;
        req_write[k] = w;
        req_addr[k]  = a;
        req_wdata[k] = d;
        req_valid[k] = 1'b1;
        wait_ready(k, tag);
        @(negedge clk);
        req_valid[k] = 1'b0;
        wait_resp(k, tag, lat);
        rd = resp_rdata[k];
        er = resp_err[k];
    endtask

    task automatic txn(input int k, input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] exp_rd, input logic exp_er, input string tag);
        logic [7:0] rd;
        logic       er;
        do_req(k, w, a, d, tag, rd, er);
        check({tag, "_rdata"}, 32'(rd), 32'(exp_rd));
        check({tag, "_err"}, 32'(er), 32'(exp_er));
    endtask

    logic [7:0] model [256];
    bit         known [256];

    initial begin
        logic [7:0] rd;
        logic       er;
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        int         lat;

        rst_n     = 3'b000;
        req_valid = 3'b000;
        req_write = 3'b000;
        for (int k = 0; k < 3; k++) begin
            req_addr[k]  = 8'h00;
            req_wdata[k] = 8'h00;
        end
        for (int i = 0; i < 256; i++) known[i] = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready[0]), 32'd0);
        check("rst_valid", 32'(resp_valid[0]), 32'd0);
        check("rst_rdata", 32'(resp_rdata[0]), 32'h00);
        check("rst_err", 32'(resp_err[0]), 32'd0);
        rst_n = 3'b111;
        @(negedge clk);
        check("rel_ready0", 32'(req_ready[0]), 32'd1);
        check("rel_ready1", 32'(req_ready[1]), 32'd1);
        check("rel_ready2", 32'(req_ready[2]), 32'd1);

        // Single store then load with two wait states.
        txn(0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0, "st10");
        txn(0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, "ld10");

        // Zero-wait build: single-cycle latency and alternating acceptance.
        txn(1, 1'b1, 8'h10, 8'h3E, 8'h00, 1'b0, "w0_st");
        txn(1, 1'b0, 8'h10, 8'h00, 8'h3E, 1'b0, "w0_ld");
        req_write[1] = 1'b0;
        req_addr[1]  = 8'h10;
        req_valid[1] = 1'b1;
        wait_ready(1, "w0_hold");
        for (int i = 0; i < 6; i++) begin
            check("w0_hold_ready", 32'(req_ready[1]), 32'((i % 2) == 0));
            check("w0_hold_valid", 32'(resp_valid[1]), 32'((i % 2) == 1));
            if ((i % 2) == 1) check("w0_hold_rdata", 32'(resp_rdata[1]), 32'h3E);
            @(negedge clk);
        end
        req_valid[1] = 1'b0;
        repeat (2) @(negedge clk);

        // Request held through WAIT of a prior access is accepted only in IDLE.
        txn(0, 1'b1, 8'h20, 8'hC3, 8'h00, 1'b0, "st20");
        req_write[0] = 1'b1;
        req_addr[0]  = 8'h30;
        req_wdata[0] = 8'h5A;
        req_valid[0] = 1'b1;
        wait_ready(0, "held_a");
        @(negedge clk);
        check("held_wait1_ready", 32'(req_ready[0]), 32'd0);
        req_write[0] = 1'b0;
        req_addr[0]  = 8'h20;
        @(negedge clk);
        check("held_wait2_ready", 32'(req_ready[0]), 32'd0);
        check("held_wait2_valid", 32'(resp_valid[0]), 32'd0);
        @(negedge clk);
        check("held_resp_a_valid", 32'(resp_valid[0]), 32'd1);
        check("held_resp_a_rdata", 32'(resp_rdata[0]), 32'h00);
        check("held_resp_a_ready", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        check("held_idle_ready", 32'(req_ready[0]), 32'd1);
        check("held_idle_valid", 32'(resp_valid[0]), 32'd0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        wait_resp(0, "held_b", lat);
        check("held_resp_b_rdata", 32'(resp_rdata[0]), 32'hC3);
        txn(0, 1'b0, 8'h30, 8'h00, 8'h5A, 1'b0, "ld30");

        // DEPTH 64: out-of-range accesses flag an error and never alias.
        txn(2, 1'b1, 8'h00, 8'h9B, 8'h00, 1'b0, "d64_st00");
        txn(2, 1'b1, 8'h40, 8'h3C, 8'h00, 1'b1, "d64_st40");
        txn(2, 1'b0, 8'h00, 8'h00, 8'h9B, 1'b0, "d64_ld00");
        txn(2, 1'b0, 8'h40, 8'h00, 8'h00, 1'b1, "d64_ld40");
        txn(2, 1'b1, 8'h3F, 8'hE7, 8'h00, 1'b0, "d64_st3f");
        txn(2, 1'b0, 8'h3F, 8'h00, 8'hE7, 1'b0, "d64_ld3f");

        // Reset in the last WAIT cycle of a store abandons it.
        txn(0, 1'b1, 8'h05, 8'h11, 8'h00, 1'b0, "st05");
        req_write[0] = 1'b1;
        req_addr[0]  = 8'h05;
        req_wdata[0] = 8'h77;
        req_valid[0] = 1'b1;
        wait_ready(0, "abort");
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        check("abort_valid0", 32'(resp_valid[0]), 32'd0);
        check("abort_ready0", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        check("abort_ready1", 32'(req_ready[0]), 32'd1);
        check("abort_valid1", 32'(resp_valid[0]), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_valid_late", 32'(resp_valid[0]), 32'd0);
        txn(0, 1'b0, 8'h05, 8'h00, 8'h11, 1'b0, "ld05");

        // Top address at default depth.
        txn(0, 1'b1, 8'hFF, 8'hFF, 8'h00, 1'b0, "st_ff");
        txn(0, 1'b0, 8'hFF, 8'h00, 8'hFF, 1'b0, "ld_ff");

        // Random traffic against a shadow memory on a small address window.
        for (int i = 0; i < 1000; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 15));
            d = 8'($urandom_range(0, 255));
            do_req(0, w, a, d, "rnd", rd, er);
            check("rnd_err", 32'(er), 32'd0);
            if (w) begin
                check("rnd_st_rdata", 32'(rd), 32'h00);
                model[a] = d;
                known[a] = 1'b1;
            end else if (known[a]) begin
                check("rnd_ld_rdata", 32'(rd), 32'(model[a]));
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("stray_resp", 32'(stray[k]), 32'd0);
            check("missing_resp", 32'(outstanding[k]), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory slave answering the CPU's load/store requests over a valid/ready request channel and a one-cycle response pulse.
- Holds an 8-bit-wide, DEPTH-entry storage array and inserts a programmable number of wait states per access.
- Sits between the CPU memory stage and the data storage; it is the responding end of the memory-access interface the memory stage initiates.

Parameters:
- DEPTH, 256, number of 8-bit words; legal range 1..256.
- WAIT_CYCLES, 2, wait states between request acceptance and response; legal range 0..15.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  8  word address.
- req_wdata  input  8  store data.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  8  load data, valid with resp_valid.
- resp_err  output  1  address out of range, valid with resp_valid.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-low: sampled only on the rising clk edge while rst_n = 0.
  - All outputs are registered.
  - Reset values: state IDLE, req_ready 0 while rst_n = 0 and 1 from the first cycle after release, resp_valid 0, resp_rdata 0x00, resp_err 0, wait counter 0.
  - The storage array is not cleared by reset.
- States:
  - IDLE: req_ready = 1.
  - WAIT: req_ready = 0; a 4-bit counter counts WAIT_CYCLES cycles.
  - RESP: req_ready = 0, resp_valid = 1.
- Transitions:
  - IDLE -> WAIT on handshake (req_valid & req_ready) when WAIT_CYCLES > 0. On the same edge, latch req_write, req_addr and req_wdata; load the counter with WAIT_CYCLES-1.
  - IDLE -> RESP directly on handshake when WAIT_CYCLES = 0.
  - WAIT: decrement the counter each cycle; go to RESP on the edge where the counter equals 0.
  - RESP -> IDLE unconditionally after one cycle.
- Latency and throughput:
  - A request accepted in cycle N produces resp_valid in cycle N+1+WAIT_CYCLES, for exactly one cycle.
  - No back-to-back acceptance: the minimum spacing between accepted requests is WAIT_CYCLES+2 cycles.
- Commit rules:
  - On the edge entering RESP, a store writes the latched data to mem[addr].
  - On the same edge, a load registers mem[addr] into resp_rdata.
  - For a store, resp_rdata = 0x00 during RESP.
  - resp_rdata and resp_err hold their last values outside RESP; only the resp_valid cycle is meaningful.
- Out of range (latched addr >= DEPTH):
  - No write is performed, resp_rdata = 0x00, resp_err = 1.
  - Latency is unchanged.
  - resp_err = 0 for every in-range access.
- Request channel:
  - Request inputs are ignored whenever req_ready = 0.
  - A requester that holds req_valid high stays pending and is accepted on the first IDLE cycle.
- Read-after-write: a load issued after a store's response to the same address returns the stored value (single outstanding transaction, so no hazard exists).
- Reset mid-operation: with rst_n = 0 in WAIT or RESP, the pending transaction is abandoned.
  - A store not yet committed is never written.
  - resp_valid is 0 in the cycle following the reset edge.
- Address width is fixed at 8. With DEPTH = 256, resp_err can never assert.

Test Plan:
- Reset then single store/load, WAIT_CYCLES=2:
  - Store 0xA5 to addr 0x10 accepted in cycle 0 -> resp_valid in cycle 3, resp_err 0.
  - Load from 0x10 accepted in cycle 5 -> resp_valid in cycle 8, resp_rdata 0xA5.
- WAIT_CYCLES=0 build:
  - Load accepted in cycle N -> resp_valid in cycle N+1.
  - With req_valid held high continuously, accepts occur every 2 cycles; req_ready low in each RESP cycle.
- Held request: assert req_valid with addr 0x20 during WAIT of a prior access -> not accepted until IDLE; exactly one response per accepted request, order preserved.
- DEPTH=64 build, store 0x3C to addr 0x40 -> resp_err 1, resp_rdata 0x00. A following load of addr 0x00 still returns its prior value with resp_err 0.
- Reset in the WAIT cycle of a store of 0x77 to 0x05, where 0x05 previously held 0x11:
  - No resp_valid follows; req_ready = 1 the cycle after reset release.
  - A subsequent load of 0x05 returns 0x11.
- Boundary: store 0xFF to addr DEPTH-1 (0xFF at default DEPTH), then load it -> 0xFF, resp_err 0. No stray resp_valid pulses outside RESP across 1000 random requests.
